// File: rtl/recarga_cartao.sv
// Card recharge front-end: accepts coins, credits one of two passenger cards
// through the turnstile controller, and refunds whatever cannot be applied.
module recarga_cartao #(
    parameter int unsigned TIMEOUT   = 15,
    parameter int unsigned SALDO_MAX = 5
) (
    input  logic       clk_2,
    input  logic       reset,
    input  logic       moeda,
    input  logic       sel,
    input  logic       confirma,
    input  logic       cancela,
    input  logic [2:0] saldo1,
    input  logic [2:0] saldo2,
    output logic [1:0] carrega1,
    output logic [1:0] carrega2,
    output logic       troco,
    output logic       rejeita,
    output logic [1:0] credito,
    output logic [1:0] estado
);

    typedef enum logic [1:0] {
        StOcioso  = 2'b00,
        StAcumula = 2'b01,
        StCarrega = 2'b10,
        StDevolve = 2'b11
    } estado_t;

    localparam logic [3:0] TIMEOUT_LIM = 4'(TIMEOUT);
    localparam logic [2:0] SALDO_LIM   = 3'(SALDO_MAX);

    estado_t    st_q;
    logic       moeda_q, confirma_q, cancela_q;
    logic [3:0] ocioso_q;
    logic       alvo_q;

    logic       moeda_ev, confirma_ev, cancela_ev;
    logic [2:0] saldo_alvo;
    logic [2:0] espaco;
    logic [1:0] aplicado;
    logic [3:0] ocioso_nxt;

    assign moeda_ev    = moeda & ~moeda_q;
    assign confirma_ev = confirma & ~confirma_q;
    assign cancela_ev  = cancela & ~cancela_q;
    assign ocioso_nxt  = ocioso_q + 4'd1;
    assign estado      = st_q;

    // Free room on the latched card and the part of the credit that fits into it
    always_comb begin
        saldo_alvo = alvo_q ? saldo2 : saldo1;
        espaco     = (saldo_alvo >= SALDO_LIM) ? 3'd0 : SALDO_LIM - saldo_alvo;
        aplicado   = ({1'b0, credito} <= espaco) ? credito : espaco[1:0];
    end

    // Edge detectors, FSM and all registered outputs
    always_ff @(posedge clk_2) begin
        // Loading the raw inputs during reset too keeps a held-high input from
        // looking like a fresh event once reset drops.
        moeda_q    <= moeda;
        confirma_q <= confirma;
        cancela_q  <= cancela;
        if (reset) begin
            st_q     <= StOcioso;
            credito  <= 2'd0;
            ocioso_q <= 4'd0;
            alvo_q   <= 1'b0;
            carrega1 <= 2'd0;
            carrega2 <= 2'd0;
            troco    <= 1'b0;
            rejeita  <= 1'b0;
        end else begin
            carrega1 <= 2'd0;
            carrega2 <= 2'd0;
            troco    <= 1'b0;
            rejeita  <= 1'b0;
            case (st_q)
                StOcioso: begin
                    if (moeda_ev) begin
                        credito  <= 2'd1;
                        ocioso_q <= 4'd0;
                        st_q     <= StAcumula;
                    end
                end
                StAcumula: begin
                    if (cancela_ev) begin
                        ocioso_q <= 4'd0;
                        st_q     <= StDevolve;
                    end else if (confirma_ev) begin
                        ocioso_q <= 4'd0;
                        alvo_q   <= sel;
                        st_q     <= StCarrega;
                    end else if (moeda_ev) begin
                        ocioso_q <= 4'd0;
                        if (credito < 2'd3) begin
                            credito <= credito + 2'd1;
                        end else begin
                            rejeita <= 1'b1;
                        end
                    end else if (ocioso_nxt == TIMEOUT_LIM) begin
                        ocioso_q <= 4'd0;
                        st_q     <= StDevolve;
                    end else begin
                        ocioso_q <= ocioso_nxt;
                    end
                end
                StCarrega: begin
                    if (alvo_q) begin
                        carrega2 <= aplicado;
                    end else begin
                        carrega1 <= aplicado;
                    end
                    credito <= credito - aplicado;
                    st_q    <= (credito != aplicado) ? StDevolve : StOcioso;
                    if (moeda_ev) begin
                        rejeita <= 1'b1;
                    end
                end
                StDevolve: begin
                    if (moeda_ev) begin
                        rejeita <= 1'b1;
                    end
                    // Zero credit here cannot happen by construction; just leave
                    if (credito == 2'd0) begin
                        st_q <= StOcioso;
                    end else begin
                        troco   <= 1'b1;
                        credito <= credito - 2'd1;
                        if (credito == 2'd1) begin
                            st_q <= StOcioso;
                        end
                    end
                end
                default: st_q <= StOcioso;
            endcase
        end
    end

endmodule

// File: tb/tb_recarga_cartao.sv
// Bench for recarga_cartao: directed scenarios plus random stimulus, all
// outputs compared every cycle against a behavioural model.
module tb_recarga_cartao;

    localparam int TMO  = 15;
    localparam int SMAX = 5;

    logic       clk_2 = 1'b0;
    logic       reset, moeda, sel, confirma, cancela;
    logic [2:0] saldo1, saldo2;
    logic [1:0] carrega1, carrega2, credito, estado;
    logic       troco, rejeita;

    recarga_cartao #(.TIMEOUT(TMO), .SALDO_MAX(SMAX)) dut (
        .clk_2    (clk_2),
        .reset    (reset),
        .moeda    (moeda),
        .sel      (sel),
        .confirma (confirma),
        .cancela  (cancela),
        .saldo1   (saldo1),
        .saldo2   (saldo2),
        .carrega1 (carrega1),
        .carrega2 (carrega2),
        .troco    (troco),
        .rejeita  (rejeita),
        .credito  (credito),
        .estado   (estado)
    );

    always #5 clk_2 = ~clk_2;

    int checks   = 0;
    int failures = 0;

    task automatic cmp(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    // States as plain numbers: 0 idle, 1 collecting, 2 charging, 3 refunding
    bit m_en = 0;
    int p_m, p_cf, p_cn;
    int m_st, m_cred, m_idle, m_tgt;
    int e_c1, e_c2, e_troco, e_rej;

    always @(posedge clk_2) begin
        int ev_m, ev_cf, ev_cn, s, space, ap;
        ev_m  = (moeda && p_m == 0) ? 1 : 0;
        ev_cf = (confirma && p_cf == 0) ? 1 : 0;
        ev_cn = (cancela && p_cn == 0) ? 1 : 0;
        p_m = int'(moeda); p_cf = int'(confirma); p_cn = int'(cancela);
        if (reset) begin
            m_st = 0; m_cred = 0; m_idle = 0; m_tgt = 0;
            e_c1 = 0; e_c2 = 0; e_troco = 0; e_rej = 0;
            m_en = 1;
        end else begin
            e_c1 = 0; e_c2 = 0; e_troco = 0; e_rej = 0;
            case (m_st)
                0: if (ev_m != 0) begin m_cred = 1; m_idle = 0; m_st = 1; end
                1: begin
                    if (ev_cn != 0) m_st = 3;
                    else if (ev_cf != 0) begin m_tgt = int'(sel); m_st = 2; end
                    else if (ev_m != 0) begin
                        if (m_cred < 3) m_cred++; else e_rej = 1;
                    end
                    if (ev_m + ev_cf + ev_cn > 0) m_idle = 0;
                    else begin
                        m_idle++;
                        if (m_idle == TMO) begin m_st = 3; m_idle = 0; end
                    end
                end
                2: begin
                    s     = (m_tgt != 0) ? int'(saldo2) : int'(saldo1);
                    space = (s >= SMAX) ? 0 : SMAX - s;
                    ap    = (m_cred < space) ? m_cred : space;
                    if (m_tgt != 0) e_c2 = ap; else e_c1 = ap;
                    m_cred = m_cred - ap;
                    m_st   = (m_cred > 0) ? 3 : 0;
                    if (ev_m != 0) e_rej = 1;
                end
                default: begin
                    if (ev_m != 0) e_rej = 1;
                    e_troco = 1;
                    m_cred--;
                    if (m_cred == 0) m_st = 0;
                end
            endcase
        end
    end

    // Per-cycle comparison plus event accumulators for directed checks
    int troco_cnt, troco_run, troco_maxrun, rej_cnt;
    int c1_pulses, c1_last, c2_pulses, c2_last;

    always @(negedge clk_2) begin
        if (m_en) begin
            cmp("estado",   int'(estado),   m_st);
            cmp("credito",  int'(credito),  m_cred);
            cmp("carrega1", int'(carrega1), e_c1);
            cmp("carrega2", int'(carrega2), e_c2);
            cmp("troco",    int'(troco),    e_troco);
            cmp("rejeita",  int'(rejeita),  e_rej);
        end
        if (troco) begin
            troco_cnt++;
            troco_run++;
            if (troco_run > troco_maxrun) troco_maxrun = troco_run;
        end else begin
            troco_run = 0;
        end
        if (rejeita) rej_cnt++;
        if (carrega1 != 2'd0) begin c1_pulses++; c1_last = int'(carrega1); end
        if (carrega2 != 2'd0) begin c2_pulses++; c2_last = int'(carrega2); end
    end

    task automatic clr();
        troco_cnt = 0; troco_run = 0; troco_maxrun = 0; rej_cnt = 0;
        c1_pulses = 0; c1_last = 0; c2_pulses = 0; c2_last = 0;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk_2);
            #2;
        end
    endtask

    task automatic coin();
        moeda = 1'b1; tick(1);
        moeda = 1'b0; tick(1);
    endtask

    initial begin
        reset = 1'b1; moeda = 1'b0; sel = 1'b0; confirma = 1'b0; cancela = 1'b0;
        saldo1 = 3'd0; saldo2 = 3'd0;
        clr();
        tick(2);
        cmp("reset_estado",  int'(estado),  0);
        cmp("reset_credito", int'(credito), 0);
        reset = 1'b0;
        tick(1);

        // A: two coins onto an empty card 1
        clr(); sel = 1'b0; saldo1 = 3'd0;
        coin(); coin();
        confirma = 1'b1; tick(1); confirma = 1'b0;
        tick(8);
        cmp("A_c1_pulses", c1_pulses, 1);
        cmp("A_c1_value",  c1_last,   2);
        cmp("A_c2_pulses", c2_pulses, 0);
        cmp("A_troco",     troco_cnt, 0);
        cmp("A_estado",    int'(estado), 0);

        // B: three coins onto card 2 holding 4 -> one applied, two refunded
        clr(); sel = 1'b1; saldo2 = 3'd4;
        coin(); coin(); coin();
        confirma = 1'b1; tick(1); confirma = 1'b0;
        tick(8);
        cmp("B_c2_pulses", c2_pulses,    1);
        cmp("B_c2_value",  c2_last,      1);
        cmp("B_c1_pulses", c1_pulses,    0);
        cmp("B_troco",     troco_cnt,    2);
        cmp("B_troco_run", troco_maxrun, 2);
        cmp("B_credito",   int'(credito), 0);

        // C: fourth coin refused
        clr();
        coin(); coin(); coin();
        cmp("C_rej_before", rej_cnt, 0);
        cmp("C_cred3",      int'(credito), 3);
        coin();
        cmp("C_rej_after",  rej_cnt, 1);
        cmp("C_cred_hold",  int'(credito), 3);
        cancela = 1'b1; tick(1); cancela = 1'b0;
        tick(8);
        cmp("C_troco", troco_cnt, 3);

        // D: confirma and cancela together -> cancel wins
        clr();
        coin(); coin();
        confirma = 1'b1; cancela = 1'b1; tick(1);
        confirma = 1'b0; cancela = 1'b0;
        tick(8);
        cmp("D_carrega", c1_pulses + c2_pulses, 0);
        cmp("D_troco",   troco_cnt, 2);
        cmp("D_estado",  int'(estado), 0);

        // E: timeout refund after 15 idle cycles
        clr();
        coin();
        tick(13);
        cmp("E_still_acumula", int'(estado), 1);
        tick(1);
        cmp("E_devolve", int'(estado), 3);
        tick(6);
        cmp("E_troco",  troco_cnt, 1);
        cmp("E_estado", int'(estado), 0);

        // F: reset in refund with credit 2, coin held high through reset
        clr();
        coin(); coin();
        cancela = 1'b1; tick(1); cancela = 1'b0;
        cmp("F_in_devolve", int'(estado), 3);
        reset = 1'b1; moeda = 1'b1;
        tick(1);
        cmp("F_estado",  int'(estado),  0);
        cmp("F_credito", int'(credito), 0);
        cmp("F_troco",   int'(troco),   0);
        reset = 1'b0;
        tick(3);
        cmp("F_no_credit", int'(credito), 0);
        cmp("F_no_troco",  troco_cnt, 0);
        moeda = 1'b0;
        tick(2);

        // Random stimulus against the model
        repeat (3000) begin
            moeda    = ($urandom_range(0, 2) == 0);
            confirma = ($urandom_range(0, 7) == 0);
            cancela  = ($urandom_range(0, 19) == 0);
            reset    = ($urandom_range(0, 149) == 0);
            sel      = 1'($urandom);
            saldo1   = 3'($urandom);
            saldo2   = 3'($urandom);
            tick(1);
        end
        reset = 1'b0; moeda = 1'b0; confirma = 1'b0; cancela = 1'b0;
        tick(30);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
